// File: rtl/fetch_pkg.sv
// Shared definitions for the pipeline-front fetch controller and the fetch unit.
//   PCSEL_*        : next-PC source codes driven on pc_sel
//   md_state_e     : multiply/divide busy-timer FSM state encoding
//   cf_flags_t     : decode-stage control-flow flags
//   pc_sel_encode  : priority encoder from control-flow flags to pc_sel
package fetch_pkg;

  localparam int unsigned PCSEL_W = 4;

  localparam logic [PCSEL_W-1:0] PCSEL_SEQ = 4'd0;
  localparam logic [PCSEL_W-1:0] PCSEL_BR  = 4'd1;
  localparam logic [PCSEL_W-1:0] PCSEL_J   = 4'd2;
  localparam logic [PCSEL_W-1:0] PCSEL_JR  = 4'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic is_jr;
    logic is_jump;
    logic is_branch;
  } cf_flags_t;

  // Register-indirect jumps win, then direct jumps, then branches.
  function automatic logic [PCSEL_W-1:0] pc_sel_encode(input cf_flags_t f);
    logic [PCSEL_W-1:0] sel;
    sel = PCSEL_SEQ;
    if (f.is_jr)          sel = PCSEL_JR;
    else if (f.is_jump)   sel = PCSEL_J;
    else if (f.is_branch) sel = PCSEL_BR;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_ctrl_md_busy_timer.sv
// Multiply/divide busy timer.
//   clk, reset : clock, asynchronous active-low reset
//   start      : execute stage issues mult/div this cycle
//   is_div     : qualifies start (1 = div, 0 = mult)
//   busy       : high for exactly MULT_CYCLES/DIV_CYCLES cycles after start
module md_busy_timer
  import fetch_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a start while already busy is ignored (no reload).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          cnt_nxt   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    busy = (state == BUSY);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Pipeline-front stall and next-PC controller for the instruction-fetch unit.
//   clk, reset      : clock, asynchronous active-low reset
//   d_is_branch/jump/jr, d_uses_md : decode-stage instruction class flags
//   load_use_stall  : load-use hazard request
//   e_md_start, e_md_is_div : execute-stage mult/div issue
//   perf_clr        : synchronous clear of stall_count
//   pc_en, pc_sel, ifid_en, idex_flush : combinational front-end controls
//   md_busy         : multiply/divide unit busy
//   stall_count     : saturating count of stalled cycles
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERF_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d_is_branch,
  input  logic               d_is_jump,
  input  logic               d_is_jr,
  input  logic               d_uses_md,
  input  logic               load_use_stall,
  input  logic               e_md_start,
  input  logic               e_md_is_div,
  input  logic               perf_clr,
  output logic               pc_en,
  output logic [PCSEL_W-1:0] pc_sel,
  output logic               ifid_en,
  output logic               idex_flush,
  output logic               md_busy,
  output logic [PERF_W-1:0]  stall_count
);

  logic      stall;
  cf_flags_t flags;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_is_div),
    .busy   (md_busy)
  );

  // A md-dependent instruction must wait while the unit is busy or just starting.
  always_comb begin
    stall         = load_use_stall | (d_uses_md & (md_busy | e_md_start));
    flags         = '0;
    flags.is_jr     = d_is_jr;
    flags.is_jump   = d_is_jump;
    flags.is_branch = d_is_branch;
  end

  // Front-end controls; reset forces the stalled/bubble pattern.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_flush = 1'b1;
    pc_sel     = PCSEL_SEQ;
    if (reset && !stall) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_flush = 1'b0;
      pc_sel     = pc_sel_encode(flags);
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int unsigned PW    = 8;
  localparam int unsigned MULTN = 5;
  localparam int unsigned DIVN  = 10;
  localparam int unsigned SATV  = (1 << PW) - 1;

  // Input vector bit masks: {br, j, jr, umd, lu, start, div, clr}
  localparam logic [7:0] B_BR = 8'h80;
  localparam logic [7:0] B_J  = 8'h40;
  localparam logic [7:0] B_JR = 8'h20;
  localparam logic [7:0] B_MD = 8'h10;
  localparam logic [7:0] B_LU = 8'h08;
  localparam logic [7:0] B_ST = 8'h04;
  localparam logic [7:0] B_DV = 8'h02;
  localparam logic [7:0] B_CL = 8'h01;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d_is_branch = 1'b0, d_is_jump = 1'b0, d_is_jr = 1'b0, d_uses_md = 1'b0;
  logic load_use_stall = 1'b0, e_md_start = 1'b0, e_md_is_div = 1'b0, perf_clr = 1'b0;
  logic          pc_en, ifid_en, idex_flush, md_busy;
  logic [3:0]    pc_sel;
  logic [PW-1:0] stall_count;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .MULT_CYCLES (MULTN),
    .DIV_CYCLES  (DIVN),
    .CNT_W       (4),
    .PERF_W      (PW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .d_is_branch    (d_is_branch),
    .d_is_jump      (d_is_jump),
    .d_is_jr        (d_is_jr),
    .d_uses_md      (d_uses_md),
    .load_use_stall (load_use_stall),
    .e_md_start     (e_md_start),
    .e_md_is_div    (e_md_is_div),
    .perf_clr       (perf_clr),
    .pc_en          (pc_en),
    .pc_sel         (pc_sel),
    .ifid_en        (ifid_en),
    .idex_flush     (idex_flush),
    .md_busy        (md_busy),
    .stall_count    (stall_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycle number, first cycle the unit is free again, stall tally.
  int cyc      = 0;
  int busy_end = 0;
  int m_cnt    = 0;

  typedef struct {
    logic [7:0] in;
    logic       pe;
    logic [3:0] sel;
    logic       ife;
    logic       fl;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [7:0] v);
    {d_is_branch, d_is_jump, d_is_jr, d_uses_md,
     load_use_stall, e_md_start, e_md_is_div, perf_clr} = v;
    #1;
  endtask

  function automatic bit m_busy();
    return reset && (cyc < busy_end);
  endfunction

  function automatic bit m_stall();
    return load_use_stall || (d_uses_md && (m_busy() || e_md_start));
  endfunction

  task automatic check_model(input string tag);
    logic       pe, ife, fl;
    logic [3:0] sel;
    if (!reset || m_stall()) begin
      pe = 1'b0; ife = 1'b0; fl = 1'b1; sel = 4'd0;
    end else begin
      pe = 1'b1; ife = 1'b1; fl = 1'b0;
      if (d_is_jr)          sel = 4'd3;
      else if (d_is_jump)   sel = 4'd2;
      else if (d_is_branch) sel = 4'd1;
      else                  sel = 4'd0;
    end
    chk({tag, ".pc_en"},       32'(pc_en),       32'(pe));
    chk({tag, ".pc_sel"},      32'(pc_sel),      32'(sel));
    chk({tag, ".ifid_en"},     32'(ifid_en),     32'(ife));
    chk({tag, ".idex_flush"},  32'(idex_flush),  32'(fl));
    chk({tag, ".md_busy"},     32'(md_busy),     32'(m_busy()));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_cnt));
  endtask

  // Advance model across the coming rising edge, then move to the next falling edge.
  task automatic edge_step();
    if (reset) begin
      if (!m_busy() && e_md_start)
        busy_end = cyc + 1 + int'(e_md_is_div ? DIVN : MULTN);
      if (perf_clr)                      m_cnt = 0;
      else if (m_stall() && m_cnt < int'(SATV)) m_cnt++;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    busy_end = cyc;
    m_cnt    = 0;
  endtask

  initial begin
    int nlow, nbusy, lastb, cnt0;
    logic [7:0] v;

    tbl[0]  = '{8'h00,                 1'b1, 4'd0, 1'b1, 1'b0};
    tbl[1]  = '{B_BR | B_J | B_JR,     1'b1, 4'd3, 1'b1, 1'b0};
    tbl[2]  = '{B_BR,                  1'b1, 4'd1, 1'b1, 1'b0};
    tbl[3]  = '{B_J,                   1'b1, 4'd2, 1'b1, 1'b0};
    tbl[4]  = '{B_J | B_BR,            1'b1, 4'd2, 1'b1, 1'b0};
    tbl[5]  = '{B_JR,                  1'b1, 4'd3, 1'b1, 1'b0};
    tbl[6]  = '{B_LU | B_J,            1'b0, 4'd0, 1'b0, 1'b1};
    tbl[7]  = '{B_LU | B_JR | B_BR,    1'b0, 4'd0, 1'b0, 1'b1};
    tbl[8]  = '{B_MD,                  1'b1, 4'd0, 1'b1, 1'b0};
    tbl[9]  = '{B_MD | B_BR,           1'b1, 4'd1, 1'b1, 1'b0};
    tbl[10] = '{B_CL | B_LU,           1'b0, 4'd0, 1'b0, 1'b1};
    tbl[11] = '{B_ST | B_MD | B_J,     1'b0, 4'd0, 1'b0, 1'b1};

    // Reset held low: forced bubble pattern.
    @(negedge clk);
    set_in(8'h00);
    check_model("reset");
    chk("reset.pc_en_const", 32'(pc_en), 32'd0);
    chk("reset.flush_const", 32'(idex_flush), 32'd1);
    edge_step();

    // Release reset with no flags.
    reset = 1'b1;
    set_in(8'h00);
    check_model("release");
    chk("release.pc_sel_const", 32'(pc_sel), 32'd0);
    edge_step();

    // Table-driven single-cycle decode behaviour.
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].in);
      chk($sformatf("tbl%0d.pc_en", i),      32'(pc_en),      32'(tbl[i].pe));
      chk($sformatf("tbl%0d.pc_sel", i),     32'(pc_sel),     32'(tbl[i].sel));
      chk($sformatf("tbl%0d.ifid_en", i),    32'(ifid_en),    32'(tbl[i].ife));
      chk($sformatf("tbl%0d.idex_flush", i), 32'(idex_flush), 32'(tbl[i].fl));
      check_model($sformatf("tbl%0d", i));
      edge_step();
    end
    for (int i = 0; i < 6; i++) begin
      set_in(8'h00);
      check_model("drain");
      edge_step();
    end

    // Mult issue with a md-dependent instruction held in decode.
    set_in(B_CL);
    edge_step();
    nlow = 0; nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(i == 0 ? (B_MD | B_ST) : B_MD);
      check_model($sformatf("mult%0d", i));
      if (!pc_en)  nlow++;
      if (md_busy) nbusy++;
      edge_step();
    end
    chk("mult.stall_cycles", 32'(nlow), 32'd6);
    chk("mult.busy_cycles",  32'(nbusy), 32'(MULTN));
    chk("mult.stall_count",  32'(stall_count), 32'd6);

    // Div issue with nothing md-dependent: no stall, count unchanged.
    cnt0 = int'(stall_count);
    nlow = 0; nbusy = 0;
    for (int i = 0; i < 13; i++) begin
      set_in(i == 0 ? (B_ST | B_DV) : 8'h00);
      check_model($sformatf("div%0d", i));
      if (!pc_en)  nlow++;
      if (md_busy) nbusy++;
      edge_step();
    end
    chk("div.busy_cycles",  32'(nbusy), 32'(DIVN));
    chk("div.stall_cycles", 32'(nlow), 32'd0);
    chk("div.stall_count",  32'(stall_count), 32'(cnt0));

    // Second start three cycles into a div is ignored.
    nbusy = 0; lastb = -1;
    for (int i = 0; i < 14; i++) begin
      set_in(i == 0 ? (B_ST | B_DV) : (i == 3 ? B_ST : 8'h00));
      check_model($sformatf("div2_%0d", i));
      if (md_busy) begin nbusy++; lastb = i; end
      edge_step();
    end
    chk("div2.busy_cycles", 32'(nbusy), 32'(DIVN));
    chk("div2.last_busy",   32'(lastb), 32'(DIVN));

    // Reset asserted mid-busy drops md_busy without a clock edge.
    set_in(B_ST);
    edge_step();
    set_in(8'h00);
    edge_step();
    chk("rstmid.busy_before", 32'(md_busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rstmid.busy_async", 32'(md_busy), 32'd0);
    check_model("rstmid");
    edge_step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(8'h00);
      check_model($sformatf("rstrel%0d", i));
      edge_step();
    end

    // Saturation, then clear taking priority over a concurrent stall.
    for (int i = 0; i < int'(SATV) + 5; i++) begin
      set_in(B_LU);
      if (i % 64 == 0) check_model($sformatf("sat%0d", i));
      edge_step();
    end
    chk("sat.value", 32'(stall_count), 32'(SATV));
    set_in(B_LU);
    edge_step();
    chk("sat.hold", 32'(stall_count), 32'(SATV));
    set_in(B_LU | B_CL);
    edge_step();
    chk("clr.value", 32'(stall_count), 32'd0);
    set_in(B_LU);
    edge_step();
    chk("clr.restart", 32'(stall_count), 32'd1);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 3) != 0)  v = v & ~B_LU;
      if ($urandom_range(0, 15) != 0) v = v & ~B_CL;
      if ($urandom_range(0, 3) != 0)  v = v & ~B_ST;
      set_in(v);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_model($sformatf("rnd_rst%0d", i));
        edge_step();
        reset = 1'b1;
        set_in(v);
      end
      check_model($sformatf("rnd%0d", i));
      edge_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
